axis_to_axi_writer: RTL and testbench
=====================================

Name: axis_to_axi_writer

Overview:
AXI-Stream sink that captures one frame (terminated by tlast) and writes it to memory through an AXI4 write master (AW/W/B channels). It is the write-direction counterpart of the stream-out reader and connects directly to axi_ram's s_axi write ports. Stream beats are staged in a local FIFO of up to MAX_BURST_LEN words. Each staged group is issued as one INCR burst at consecutive addresses.

Parameters:
DATA_WIDTH, 32, AXI and stream data width in bits
ADDR_WIDTH, 16, AXI address width in bits
STRB_WIDTH, DATA_WIDTH/8, write-strobe width in bits
ID_WIDTH, 8, AXI ID width in bits; awid is driven to 0
MAX_BURST_LEN, 16, maximum beats per burst; power of 2, range 1..256

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
start_addr  in  ADDR_WIDTH  byte address of the first word; latched when start is accepted
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  marks the last beat of the frame
m_axi_awid  out  ID_WIDTH  constant 0
m_axi_awaddr  out  ADDR_WIDTH  burst start address
m_axi_awlen  out  8  beats minus 1
m_axi_awsize  out  3  log2(STRB_WIDTH)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_wdata  out  DATA_WIDTH  write data from the FIFO head
m_axi_wstrb  out  STRB_WIDTH  all ones
m_axi_wlast  out  1  final beat of the burst
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  B ready
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the frame is complete
error  out  1  sticky flag; set when any bresp != 2'b00, cleared on the next accepted start
beat_count  out  16  total beats written in the current or last frame

Behaviour:
- Reset: all valids 0, s_axis_tready 0, m_axi_bready 0, busy 0, done 0, error 0, beat_count 0, FIFO emptied, state IDLE.
- States: IDLE, FILL, ADDR, DATA, RESP, DONE.
- IDLE: start=1 -> latch start_addr into the address register (low log2(STRB_WIDTH) bits forced to 0); clear error and beat_count; busy<=1; go to FILL.
- FILL: s_axis_tready = (fill_cnt < MAX_BURST_LEN). Each tvalid&&tready beat is pushed and fill_cnt increments.
  - Burst closes when the accepted beat is tlast, or when fill_cnt reaches MAX_BURST_LEN. Record frame_end = tlast, then go to ADDR.
  - tready is 0 in every state other than FILL.
- ADDR: awvalid=1, awaddr = address register, awlen = fill_cnt-1. Hold all AW signals stable until awready. awvalid is registered, so it asserts the cycle after the burst closes. On handshake, go to DATA.
- DATA: wvalid=1 while the FIFO is non-empty. wdata = FIFO head. wlast=1 when exactly 1 entry remains. Each wready handshake pops one entry and increments beat_count. After the wlast handshake, go to RESP.
- RESP: bready=1. On bvalid: if bresp != 0, set error. Then:
  - frame_end=1 -> DONE.
  - otherwise add burst_beats*STRB_WIDTH to the address register, clear fill_cnt, go to FILL.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.
- AW is never issued before all of its W data is staged, so AW-before-W ordering always holds. Only one burst is outstanding at a time.
- The address wraps modulo 2^ADDR_WIDTH. The block does not split bursts at 4 KB boundaries. Callers align start_addr to MAX_BURST_LEN*STRB_WIDTH.
- start outside IDLE is ignored.
- tvalid gaps and awready/wready backpressure only stall the block; they never drop or duplicate data.
- A frame longer than 65535 beats wraps beat_count; the write itself still completes.
- rst mid-operation: return to the reset values on the next edge; the partial burst is abandoned. The attached slave shares rst.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_INCR = 2'b01
  - AXI_RESP_OKAY = 2'b00
  - AXI_RESP_SLVERR = 2'b10
  - state encoding constants shared with the reader FSM
  - function clog2 for awsize
- One sub-module: sync_fifo (DATA_WIDTH wide, MAX_BURST_LEN deep). Ports: push, pop, dout, count, full, empty. dout is a first-word-fall-through output.

Test Plan:
- 6-beat frame 0x11..0x16, start_addr 0x0100, DUT connected to axi_ram -> one AW with addr 0x0100, len 5, size 2; 6 W beats with wlast on the 6th; done pulses; beat_count=6; readback from 0x0100..0x0114 matches.
- 40-beat frame, MAX_BURST_LEN 16, start_addr 0x0000 -> three bursts: addr 0x000/len 15, 0x040/len 15, 0x080/len 7; beat_count=40; RAM contents match.
- 1-beat frame (tlast on the first beat), start_addr 0x0200 -> awlen 0; wlast asserted with the single W beat; done occurs after B.
- Random tvalid gaps plus random awready/wready stalls, 100-beat frame -> RAM contents bit-exact; no AW handshake ever precedes full staging; tready is 0 outside FILL.
- Stub slave returns bresp=2'b10 on the second of three bursts -> error rises and stays high; done still pulses; error clears on the next start.
- Assert rst during the DATA state of the second burst -> the following cycle has all valids, tready, busy and done at 0; a new start then completes a 4-beat frame correctly.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, transfer FSM encoding and helpers
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Common encoding for the stream-in writer and stream-out reader FSMs
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4,
    ST_DONE = 3'd5
  } xfer_state_t;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_to_axi_writer_if.sv
// rtl/axis_to_axi_writer_if.sv - stream sink and AXI4 write-master bundle
interface axis_to_axi_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;

  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  // master: the writer; slave: stream source plus memory side
  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through output
module sync_fifo
  import axi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [clog2(DEPTH + 1)-1:0]  count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_to_axi_writer.sv
// rtl/axis_to_axi_writer.sv - captures one stream frame and writes it out as INCR bursts
module axis_to_axi_writer
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  axis_to_axi_writer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           beat_count
);
  localparam int ASIZE = clog2(STRB_WIDTH);
  localparam int CW    = clog2(MAX_BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  xfer_state_t           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         fill_cnt;
  logic                  frame_end;
  logic [7:0]            awlen_q;
  logic                  tready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic                  push, pop, close_burst;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;

  assign push        = bus.s_axis_tvalid & tready_q & ~fifo_full;
  assign pop         = wvalid_q & bus.m_axi_wready;
  assign close_burst = push & (bus.s_axis_tlast | (fill_cnt == CW'(MAX_BURST_LEN - 1)));

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_BURST_LEN)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.s_axis_tdata),
    .pop   (pop),
    .dout  (bus.m_axi_wdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.s_axis_tready = tready_q;
  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = 3'(ASIZE);
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = wlast_q;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      fill_cnt   <= '0;
      frame_end  <= 1'b0;
      awlen_q    <= '0;
      tready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      beat_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          addr_q     <= start_addr & ALIGN_MASK;
          error      <= 1'b0;
          beat_count <= '0;
          busy       <= 1'b1;
          fill_cnt   <= '0;
          tready_q   <= 1'b1;
          state      <= ST_FILL;
        end
        ST_FILL: if (push) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (close_burst) begin
            tready_q  <= 1'b0;
            frame_end <= bus.s_axis_tlast;
            awvalid_q <= 1'b1;
            awlen_q   <= 8'(fill_cnt);
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: if (bus.m_axi_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= ~fifo_empty;
          wlast_q   <= (fifo_count == CW'(1));
          state     <= ST_DATA;
        end
        // wlast looks one pop ahead: after this pop, is exactly one entry left?
        ST_DATA: if (pop) begin
          beat_count <= beat_count + 16'd1;
          if (wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state    <= ST_RESP;
          end else begin
            wlast_q <= (fifo_count == CW'(2));
          end
        end
        ST_RESP: if (bus.m_axi_bvalid) begin
          bready_q <= 1'b0;
          if (bus.m_axi_bresp != AXI_RESP_OKAY) error <= 1'b1;
          if (frame_end) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            addr_q   <= addr_q + (ADDR_WIDTH'(fill_cnt) << ASIZE);
            fill_cnt <= '0;
            tready_q <= 1'b1;
            state    <= ST_FILL;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_axi_writer.sv
// tb/tb_axis_to_axi_writer.sv - scoreboard bench with a behavioural AXI write slave
module tb_axis_to_axi_writer;
  import axi_pkg::*;

  localparam int DW = 32, AW = 16, IW = 8, MB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic busy, done, error;
  logic [15:0] beat_count;

  axis_to_axi_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axis_to_axi_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST_LEN(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [23:0] exp_aw [$];
  logic [36:0] exp_w [$];
  logic [31:0] ram [0:16383];
  logic [AW-1:0] wr_addr = '0;
  int cyc = 0, aw_count = 0, staged = 0, viol = 0, done_pulses = 0;
  int done_cyc = 0, last_b_cyc = 0, b_count = 0, err_burst = 0;
  bit stall_en = 0, b_owed = 0, b_hs_f = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: decides at negedge which handshakes complete on the coming edge
  initial forever begin
    @(negedge clk);
    b_hs_f = 0;
    if (rst) begin
      staged = 0;
    end else begin
      if (bus.s_axis_tvalid && bus.s_axis_tready) staged++;
      if (bus.s_axis_tready && (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_bready || !busy)) viol++;
      if (done) begin done_pulses++; done_cyc = cyc; end
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_count++;
        check("aw_staged", staged, int'(bus.m_axi_awlen) + 1);
        staged = 0;
        check("aw_fixed", {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst}, {8'h00, 3'd2, 2'b01});
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else check("aw_addr_len", {bus.m_axi_awaddr, bus.m_axi_awlen}, exp_aw.pop_front());
        wr_addr = bus.m_axi_awaddr;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else check("w_strb_last_data", {bus.m_axi_wstrb, bus.m_axi_wlast, bus.m_axi_wdata}, exp_w.pop_front());
        ram[wr_addr[AW-1:2]] = bus.m_axi_wdata;
        wr_addr = wr_addr + 16'd4;
        if (bus.m_axi_wlast) b_owed = 1;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        b_hs_f = 1;
        b_count++;
        last_b_cyc = cyc;
      end
    end
  end

  // Slave driver: ready/response updates just after each rising edge
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      bus.m_axi_awready = 0; bus.m_axi_wready = 0;
      bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00; b_owed = 0;
    end else begin
      bus.m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_axi_wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (b_hs_f) bus.m_axi_bvalid = 0;
      if (b_owed && !bus.m_axi_bvalid) begin
        bus.m_axi_bvalid = 1;
        bus.m_axi_bresp = (b_count + 1 == err_burst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        b_owed = 0;
      end
    end
  end

  task automatic expect_w(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int len_left;
      len_left = n - (i / MB) * MB;
      exp_w.push_back({4'hF, ((i % MB) == MB - 1) || (i == n - 1), 32'(base + 32'(i))});
      if (len_left < 0) check("expect_w_len", 0, 1);
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int t;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        bus.s_axis_tvalid = 0; @(posedge clk); #1;
      end
      bus.s_axis_tvalid = 1;
      bus.s_axis_tdata = base + 32'(i);
      bus.s_axis_tlast = (i == n - 1);
      acc = 0; t = 0;
      while (!acc && t < 2000) begin
        @(negedge clk); acc = bus.s_axis_tready;
        @(posedge clk); #1; t++;
      end
      if (!acc) begin
        check("stream_accept", acc, 1);
        bus.s_axis_tvalid = 0;
        return;
      end
    end
    bus.s_axis_tvalid = 0;
    bus.s_axis_tlast = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] addr);
    aw_count = 0; done_pulses = 0;
    start = 1; start_addr = addr;
    @(posedge clk); #1;
    start = 0;
    check("error_clear_on_start", error, 0);
  endtask

  task automatic run_frame(input logic [AW-1:0] addr, input int n, input logic [31:0] base,
                           input bit gaps, input logic exp_err);
    int t, bad;
    pulse_start(addr);
    send_frame(n, base, gaps);
    t = 0;
    while (done_pulses == 0 && t < 5000) begin @(posedge clk); #1; t++; end
    check("done_seen", done_pulses != 0, 1);
    repeat (2) begin @(posedge clk); #1; end
    check("done_one_pulse", done_pulses, 1);
    check("done_after_b", done_cyc > last_b_cyc, 1);
    check("busy_after_done", busy, 0);
    check("beat_count", beat_count, n);
    check("error_flag", error, exp_err);
    check("aw_all_seen", exp_aw.size(), 0);
    check("w_all_seen", exp_w.size(), 0);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (int'(addr) >> 2) + i;
      if (ram[idx[13:0]] !== base + 32'(i)) bad++;
    end
    check("ram_readback", bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int t;
    bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_tready", bus.s_axis_tready, 0);
    check("rst_awvalid", bus.m_axi_awvalid, 0);
    check("rst_wvalid", bus.m_axi_wvalid, 0);
    check("rst_bready", bus.m_axi_bready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_beat_count", beat_count, 0);
    rst = 0;
    @(posedge clk); #1;

    exp_aw.push_back({16'h0100, 8'd5});
    expect_w(6, 32'h11);
    run_frame(16'h0100, 6, 32'h11, 0, 0);

    exp_aw.push_back({16'h0000, 8'd15});
    exp_aw.push_back({16'h0040, 8'd15});
    exp_aw.push_back({16'h0080, 8'd7});
    expect_w(40, 32'h1000_0000);
    run_frame(16'h0000, 40, 32'h1000_0000, 0, 0);

    exp_aw.push_back({16'h0200, 8'd0});
    expect_w(1, 32'hDEAD_BEEF);
    run_frame(16'h0200, 1, 32'hDEAD_BEEF, 0, 0);

    stall_en = 1;
    for (int k = 0; k < 6; k++) exp_aw.push_back({16'h0400 + 16'(k * 64), 8'd15});
    exp_aw.push_back({16'h0580, 8'd3});
    expect_w(100, 32'hC000_0000);
    run_frame(16'h0400, 100, 32'hC000_0000, 1, 0);
    stall_en = 0;

    err_burst = 2; b_count = 0;
    exp_aw.push_back({16'h0800, 8'd15});
    exp_aw.push_back({16'h0840, 8'd15});
    exp_aw.push_back({16'h0880, 8'd15});
    expect_w(48, 32'h5000_0000);
    run_frame(16'h0800, 48, 32'h5000_0000, 0, 1);
    err_burst = 0;

    exp_aw.push_back({16'h0C00, 8'd15});
    exp_aw.push_back({16'h0C40, 8'd3});
    expect_w(20, 32'h6000_0000);
    pulse_start(16'h0C00);
    send_frame(20, 32'h6000_0000, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(aw_count == 2 && bus.m_axi_wvalid) && t < 200);
    check("reached_second_data", t < 200, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_outputs",
          {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.s_axis_tready, busy, done}, 6'b0);
    check("mid_rst_beat_count", beat_count, 0);
    exp_aw.delete();
    exp_w.delete();
    rst = 0;
    @(posedge clk); #1;

    exp_aw.push_back({16'h0E00, 8'd3});
    expect_w(4, 32'h7000_0000);
    run_frame(16'h0E00, 4, 32'h7000_0000, 0, 0);

    check("tready_outside_fill", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
